// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline run/debug sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipeline_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_RUN   = 3'd3,
        ST_HALT  = 3'd4,
        ST_STEP  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        CMD_RUN    = 2'b00,
        CMD_HALT   = 2'b01,
        CMD_STEP   = 2'b10,
        CMD_RELOAD = 2'b11
    } cmd_t;

    localparam int unsigned FLUSH_CYC_DEF = 4;

    // Flush/step down-counter width; FLUSH_CYC and STEP_CNT both fit in 8 bits.
    localparam int unsigned CTR_W = 8;

    // A step count of zero still advances the pipeline once.
    function automatic logic [7:0] step_len(input logic [7:0] n);
        return (n == 8'd0) ? 8'd1 : n;
    endfunction

endpackage

// File: rtl/imem_load_port.sv
// Instruction-memory write port: word pointer, registered write strobe, overflow flag.
// Latency: beat accepted at edge k is written (WE/ADDR/WDATA) during cycle k+1.
// Backpressure: none internally; the caller gates acc with its own ready.
module imem_load_port #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              acc,
    input  logic              last,
    input  logic [31:0]       data,
    output logic              done,
    output logic              ovf,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata
);

    // Highest word-aligned address: the beat written here without LAST overflows.
    localparam logic [ADDR_W-1:0] PTR_MAX = {{(ADDR_W-2){1'b1}}, 2'b00};

    logic [ADDR_W-1:0] ptr_q;
    logic              at_end;
    logic              ovf_hit;

    assign at_end  = (ptr_q == PTR_MAX);
    assign done    = acc && (last || at_end);
    assign ovf_hit = acc && !last && at_end;

    // Write pointer: cleared at load start, advances one word per beat, wraps past the end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (clr) begin
            ptr_q <= '0;
        end else if (acc) begin
            ptr_q <= ptr_q + ADDR_W'(4);
        end
    end

    // Sticky overflow flag, cleared when a new load starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (clr) begin
            ovf <= 1'b0;
        end else if (ovf_hit) begin
            ovf <= 1'b1;
        end
    end

    // Registered write port; address and data hold between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= acc;
            if (acc) begin
                imem_addr  <= ptr_q;
                imem_wdata <= data;
            end
        end
    end

endmodule

// File: rtl/pipeline_run_ctrl.sv
// Run/debug sequencer: image load, flush, run/halt/step and executed-cycle count.
// Latency: accepted command shows its new state and outputs the following cycle.
// Backpressure: CMD_READY low in LOAD/FLUSH/STEP; LD_READY high only in LOAD.
module pipeline_run_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int FLUSH_CYC = FLUSH_CYC_DEF,
    parameter int CNT_W     = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              LD_VALID,
    output logic              LD_READY,
    input  logic [31:0]       LD_DATA,
    input  logic              LD_LAST,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic [1:0]        CMD,
    input  logic [7:0]        STEP_CNT,
    input  logic [ADDR_W-1:0] STOP_ADDR,
    input  logic [ADDR_W-1:0] FRONT_Q,
    output logic              CPU_RST,
    output logic              CPU_EN,
    output logic              IMEM_WE,
    output logic [ADDR_W-1:0] IMEM_ADDR,
    output logic [31:0]       IMEM_WDATA,
    output logic [2:0]        STATE,
    output logic              DONE,
    output logic              OVF,
    output logic [CNT_W-1:0]  CYCLE_CNT
);

    state_t             state_q, state_d;
    cmd_t               cmd_c;
    logic [CTR_W-1:0]   ctr_q;
    logic [CNT_W-1:0]   cyc_q;
    logic               loaded_q;
    logic               done_q;
    logic               cmd_acc;
    logic               ld_acc;
    logic               ld_done;
    logic               stop_hit;
    logic               load_start;
    logic               run_start;
    logic               step_start;

    assign cmd_c      = cmd_t'(CMD);
    assign cmd_acc    = CMD_VALID && CMD_READY;
    assign ld_acc     = LD_VALID && LD_READY;
    assign stop_hit   = (FRONT_Q == STOP_ADDR);
    assign load_start = cmd_acc && (cmd_c == CMD_RELOAD) &&
                        ((state_q == ST_IDLE) || (state_q == ST_HALT));
    assign run_start  = cmd_acc && (cmd_c == CMD_RUN) && (state_q == ST_IDLE) && loaded_q;
    assign step_start = cmd_acc && (cmd_c == CMD_STEP) && (state_q == ST_HALT);

    imem_load_port #(.ADDR_W(ADDR_W)) u_load (
        .clk        (CLK),
        .rst_n      (RST),
        .clr        (load_start),
        .acc        (ld_acc),
        .last       (LD_LAST),
        .data       (LD_DATA),
        .done       (ld_done),
        .ovf        (OVF),
        .imem_we    (IMEM_WE),
        .imem_addr  (IMEM_ADDR),
        .imem_wdata (IMEM_WDATA)
    );

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a stop match takes priority over any command.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (load_start)     state_d = ST_LOAD;
                else if (run_start) state_d = ST_FLUSH;
            end
            ST_LOAD: begin
                if (ld_done) state_d = ST_IDLE;
            end
            ST_FLUSH: begin
                if (ctr_q == '0) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (stop_hit || (cmd_acc && (cmd_c == CMD_HALT))) state_d = ST_HALT;
            end
            ST_HALT: begin
                if (load_start)                              state_d = ST_LOAD;
                else if (step_start)                         state_d = ST_STEP;
                else if (cmd_acc && (cmd_c == CMD_RUN))      state_d = ST_RUN;
            end
            ST_STEP: begin
                if (stop_hit || (ctr_q == '0)) state_d = ST_HALT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from the registered state, so outputs only move on clock edges.
    always_comb begin
        CPU_RST   = 1'b1;
        CPU_EN    = 1'b0;
        LD_READY  = 1'b0;
        CMD_READY = 1'b0;
        unique case (state_q)
            ST_IDLE:  begin CPU_RST = 1'b1; CMD_READY = 1'b1; end
            ST_LOAD:  begin CPU_RST = 1'b1; LD_READY  = 1'b1; end
            ST_FLUSH: begin CPU_RST = 1'b1; CPU_EN    = 1'b1; end
            ST_RUN:   begin CPU_RST = 1'b0; CPU_EN    = 1'b1; CMD_READY = 1'b1; end
            ST_HALT:  begin CPU_RST = 1'b0; CMD_READY = 1'b1; end
            ST_STEP:  begin CPU_RST = 1'b0; CPU_EN    = 1'b1; end
            default:  begin CPU_RST = 1'b1; CMD_READY = 1'b1; end
        endcase
    end

    // Flush/step down-counter: loaded with length-1, state leaves when it reads 0.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ctr_q <= '0;
        end else if (run_start) begin
            ctr_q <= CTR_W'(FLUSH_CYC - 1);
        end else if (step_start) begin
            ctr_q <= step_len(STEP_CNT) - 8'd1;
        end else if (((state_q == ST_FLUSH) || (state_q == ST_STEP)) && (ctr_q != '0)) begin
            ctr_q <= ctr_q - 1'b1;
        end
    end

    // Image-present flag; only a reset forgets the image.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            loaded_q <= 1'b0;
        end else if (ld_done) begin
            loaded_q <= 1'b1;
        end
    end

    // Sticky stop-address flag, cleared when a new run begins its flush.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            done_q <= 1'b0;
        end else if (run_start) begin
            done_q <= 1'b0;
        end else if (((state_q == ST_RUN) || (state_q == ST_STEP)) && stop_hit) begin
            done_q <= 1'b1;
        end
    end

    // Saturating count of cycles in which the pipeline really advanced.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cyc_q <= '0;
        end else if (run_start) begin
            cyc_q <= '0;
        end else if (CPU_EN && !CPU_RST && (cyc_q != {CNT_W{1'b1}})) begin
            cyc_q <= cyc_q + 1'b1;
        end
    end

    assign STATE     = state_q;
    assign DONE      = done_q;
    assign CYCLE_CNT = cyc_q;

endmodule

// File: doc/pipeline_run_ctrl.md
# pipeline_run_ctrl

Run/debug sequencer for the five-stage pipeline. It loads a program image into instruction memory over a valid/ready stream and holds the pipeline in reset during the load. It flushes the pipeline registers, then runs, halts, single-steps or multi-steps the pipeline on command, and counts executed cycles. It sits above the pipeline top: it drives the pipeline's reset and global enable, and it drives the instruction-memory write port.

## Interface
Parameters:
- `ADDR_W`, 8: instruction-memory byte-address width. Words are 4 bytes, word-aligned.
- `FLUSH_CYC`, 4: number of cycles the pipeline is clocked under reset before RUN.
- `CNT_W`, 32: width of the cycle counter.

Ports:
- `CLK` in 1: the single clock. All logic is rising-edge.
- `RST` in 1: reset, asynchronous, active-low.
- `LD_VALID` in 1 / `LD_READY` out 1 / `LD_DATA` in 32 / `LD_LAST` in 1: program-image stream.
- `CMD_VALID` in 1 / `CMD_READY` out 1 / `CMD` in 2: command. RUN=00, HALT=01, STEP=10, RELOAD=11.
- `STEP_CNT` in 8: cycles per STEP, sampled when STEP is accepted. 0 is treated as 1.
- `STOP_ADDR` in ADDR_W: fetch address that ends a program.
- `FRONT_Q` in ADDR_W: the pipeline's current fetch address.
- `CPU_RST` out 1: active-high reset to the pipeline.
- `CPU_EN` out 1: global pipeline advance enable.
- `IMEM_WE` out 1 / `IMEM_ADDR` out ADDR_W / `IMEM_WDATA` out 32: instruction-memory write port.
- `STATE` out 3: current state encoding.
- `DONE` out 1: sticky flag, stop address reached.
- `OVF` out 1: sticky flag, image exceeded memory.
- `CYCLE_CNT` out CNT_W: executed-cycle count.

## Operation
- States: IDLE, LOAD, FLUSH, RUN, HALT, STEP.
- Reset values: IDLE, `CPU_RST`=1, `CPU_EN`=0, `LD_READY`=0, `CMD_READY`=1, `IMEM_WE`=0, `IMEM_ADDR`=0, `IMEM_WDATA`=0, `DONE`=0, `OVF`=0, `CYCLE_CNT`=0, internal `loaded`=0.
- IDLE: `CPU_RST`=1, `CPU_EN`=0.
  - RELOAD → LOAD; the write pointer is cleared and `OVF` is cleared.
  - RUN → FLUSH if `loaded`=1; otherwise RUN is ignored.
  - HALT and STEP are ignored.
- LOAD: `LD_READY`=1, `CMD_READY`=0, `CPU_RST`=1.
  - Each accepted beat (`LD_VALID`&&`LD_READY`) writes `LD_DATA` at the current pointer, then the pointer advances by 4.
  - Accepted beat with `LD_LAST`=1 → IDLE, `loaded`=1.
  - Accepted beat at pointer 2^ADDR_W−4 with `LD_LAST`=0 → the beat is written, `OVF`=1, → IDLE, `loaded`=1. The pointer wraps to 0 and is never reused.
- FLUSH: `CPU_RST`=1, `CPU_EN`=1 for exactly `FLUSH_CYC` cycles, then → RUN. `CMD_READY`=0. `CYCLE_CNT` and `DONE` are cleared on entry.
- RUN: `CPU_RST`=0, `CPU_EN`=1, `CMD_READY`=1.
  - HALT → HALT.
  - `FRONT_Q`==`STOP_ADDR` → HALT with `DONE`=1.
  - HALT command and stop match in the same cycle → HALT with `DONE`=1.
  - Other commands are accepted and ignored.
- HALT: `CPU_RST`=0, `CPU_EN`=0, so pipeline state is frozen.
  - RUN → RUN.
  - STEP → STEP with remaining count = max(`STEP_CNT`,1).
  - RELOAD → LOAD; `CPU_RST` rises in the same cycle as the state change.
- STEP: `CPU_EN`=1, `CMD_READY`=0.
  - The count decrements each cycle; reaching 0 → HALT.
  - A stop match → HALT immediately with `DONE`=1.
- `CYCLE_CNT`: +1 each cycle in which `CPU_EN`=1 and `CPU_RST`=0; saturates at all-ones.
- Reset mid-operation (any state): return to reset values. `loaded` is cleared, so an image must be reloaded.

## Timing
- All outputs are registered and change only on `CLK` rising edge, except on asynchronous reset assertion.
- A command is accepted on a `CMD_VALID`&&`CMD_READY` edge. The new state and its outputs are visible the next cycle.
- A load beat is accepted at edge k. `IMEM_WE`=1 with its address and data during cycle k+1. `IMEM_WE` is a one-cycle pulse per beat.
- Back-to-back beats are sustained at 1 per cycle.
- The final load beat's write is issued in the first IDLE cycle.
- FLUSH lasts exactly `FLUSH_CYC` cycles. The first RUN cycle has `CPU_RST`=0.
- STEP with N: `CPU_EN`=1 for exactly N consecutive cycles, then 0.
- Stop detection compares registered `FRONT_Q`. `CPU_EN` drops the cycle after the match edge, so the pipeline advances at most one cycle past the match.

## Structure
- Shared package `pipeline_ctrl_pkg`: state encodings (IDLE=0, LOAD=1, FLUSH=2, RUN=3, HALT=4, STEP=5), command codes, default `FLUSH_CYC`.
- One sub-module, `imem_load_port`: owns the pointer, the registered write port and overflow detection. It takes an accept strobe and the last flag, and reports done/overflow.
- The FSM, flush/step counter and cycle counter live in `pipeline_run_ctrl`.

## Test plan
- Reset, then RELOAD, then 3 beats 0x11,0x22,0x33 with LAST on the third: WE pulses at addresses 0,4,8 with that data; → IDLE; `loaded`=1; `OVF`=0.
- RUN issued before any load: ignored; `STATE` stays IDLE; `CPU_RST`=1.
- Loaded image, RUN, `STOP_ADDR`=0x10, `FRONT_Q` ramps by 4 from 0: `CPU_RST`=1 for 4 cycles; RUN until the match; then HALT, `DONE`=1, and `CYCLE_CNT` equals the number of RUN cycles.
- In HALT, STEP with `STEP_CNT`=3: `CPU_EN`=1 for exactly 3 cycles, `CYCLE_CNT`+3, back to HALT. Then STEP with `STEP_CNT`=0: exactly 1 cycle.
- 64 beats without LAST (`ADDR_W`=8): last write at address 252, `OVF`=1, → IDLE. A further beat is not accepted (`LD_READY`=0).
- `RST` asserted mid-LOAD at beat 2: all outputs at reset values immediately. Then RUN: ignored, because `loaded`=0.
